midi_uart_rx: RTL
=================

Name: midi_uart_rx

Overview:
- Serial front end of the MIDI input path.
- Oversamples the raw MIDI opto-isolator output at 50 MHz and deframes 31250-baud 8N1 UART frames.
- Presents each received byte as a one-cycle strobe that drives the MIDI decoder's byte input (data_in / data_in_ready) directly.
- Also reports framing errors for status LEDs and debug.

Parameters:
- CLOCK_HZ, 50_000_000, system clock frequency.
- BAUD, 31_250, MIDI bit rate.
- CLKS_PER_BIT, CLOCK_HZ/BAUD (=1600), clocks per bit. Localparam; must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (=800), offset from start edge to the mid-bit sample. Localparam.

Ports:
- clock_50_000_000  in   1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  raw asynchronous MIDI serial line. Idles high.
- data  out  8  last received byte. Valid while data_ready=1 and held until the next accepted byte.
- data_ready  out  1  one-cycle strobe: data holds a new byte.
- framing_error  out  1  one-cycle strobe: stop bit was sampled low.
- busy  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Interface: one clock (clock_50_000_000). Reset is synchronous and active-high (reset).
- Reset values:
  - data=8'h00, data_ready=0, framing_error=0, busy=0.
  - state=IDLE, counter=0, bit index=0.
  - Both synchronizer flops preset to 1 (line idle).
- Synchronizer: 2-flop synchronizer on rx; rx_s is the second flop output. All decisions use rx_s only. Pin-to-rx_s latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, RECOVER.
- IDLE:
  - rx_s=0 → START, counter=0, busy=1.
  - Only a low level at IDLE triggers a frame; no edge detector is needed because RECOVER guarantees the line was high first.
- START:
  - When counter reaches HALF_BIT-1, sample rx_s.
  - rx_s=0 → DATA, counter=0, bit index=0.
  - rx_s=1 → glitch: back to IDLE, no strobe, busy=0.
- DATA:
  - Each time counter reaches CLKS_PER_BIT-1, sample rx_s into shift register bit[index]. Bits arrive LSB first.
  - Counter resets on each sample. After index 7 is sampled → STOP.
- STOP (at CLKS_PER_BIT-1):
  - rx_s=1: on the next cycle data ← shift register, data_ready=1 for exactly 1 cycle; → IDLE.
  - rx_s=0: framing_error=1 for 1 cycle, data unchanged, no data_ready; → RECOVER.
- RECOVER: wait for rx_s=1, then → IDLE. A break condition (line held low) therefore produces one error only.
- Timing:
  - With T0 = first cycle rx_s=0 in IDLE: start sample at T0+800, data bit k sampled at T0+800+1600·(k+1), stop at T0+15200.
  - data_ready asserts at T0+15201 (pin-to-strobe = T0+15203 relative to pin).
- Counter width is clog2(CLKS_PER_BIT). It never wraps because it is cleared on every sample point.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE is re-entered one cycle after the stop sample, which is well inside the 800-cycle half bit.
- Reset asserted mid-frame: aborts at once to the reset values above. No strobe is emitted for the partial byte.
- data_ready and framing_error are never high in the same cycle.
- No backpressure: the consumer must accept each byte on its strobe.

Optional Feature:
- MIDI_RX_REALTIME_FILTER_EN
- Defined: received bytes 8'hF8–8'hFF (System Real-Time: clock, start, stop, active sensing, reset) are discarded after a valid stop bit. No data_ready, data unchanged. This keeps them from corrupting running-status parsing downstream.
- Undefined: every correctly framed byte is forwarded.

Test Plan:
- Reset idle: hold rx=1 for 5000 cycles after reset → data=00, data_ready, framing_error and busy all stay 0.
- Single byte: send 0x90 (start 0, bits 0,0,0,0,1,0,0,1, stop 1) at 1600 clk/bit → exactly one data_ready pulse, data=0x90, 15203±1 cycles after the start edge on rx.
- Note-on stream: send 0x90, 0x0A, 0x50 back-to-back with no idle gap → three strobes 16000 cycles apart carrying 0x90, 0x0A, 0x50. Feeding them into the decoder yields one NOTE_ON message (note 10, velocity 80).
- Glitch and framing:
  - A 400-cycle low pulse on idle rx → no strobe, busy falls by T0+801.
  - A frame with stop=0 → framing_error pulse, no data_ready.
  - Holding rx low for a further 50000 cycles → no additional errors. The next good byte 0x3C is received correctly.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 4 of 0xB0 → outputs return to reset values, no strobe. The next full frame 0x07 is received as 0x07.
- Filter: send 0xFE then 0x80 → with MIDI_RX_REALTIME_FILTER_EN only 0x80 is strobed. Without it, 0xFE then 0x80 are both strobed.

Source files
------------

// File: rtl/midi_uart_rx.sv
// ============================================================================
// Module   : midi_uart_rx
// Purpose  : MIDI serial receiver. Oversamples the raw opto-isolator output
//            at the system clock and deframes 8N1 UART frames at the MIDI
//            baud rate. Each good byte is presented as a one-cycle strobe
//            that feeds the MIDI decoder's byte input directly. Bad stop
//            bits are reported as a one-cycle framing_error strobe.
// Ports    : clock_50_000_000 - system clock, rising edge
//            reset            - synchronous, active-high
//            rx               - raw asynchronous serial line (idles high)
//            data[7:0]        - last accepted byte, held until the next one
//            data_ready       - one-cycle strobe, data holds a new byte
//            framing_error    - one-cycle strobe, stop bit sampled low
//            busy             - a frame is in progress (state != IDLE)
// Options  : `define MIDI_RX_REALTIME_FILTER_EN to drop System Real-Time
//            bytes (8'hF8..8'hFF) after a valid stop bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_uart_rx #(
  parameter int CLOCK_HZ = 50_000_000,
  parameter int BAUD     = 31_250
) (
  input  logic       clock_50_000_000,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud_ratio
      $error("midi_uart_rx: CLOCK_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Two-flop synchronizer; both flops preset high so reset looks like idle line.
  logic             rx_meta_q;
  logic             rx_s_q;

  state_t           state_q,         state_d;
  logic [CNT_W-1:0] cnt_q,           cnt_d;
  logic [2:0]       idx_q,           idx_d;
  logic [7:0]       shift_q,         shift_d;
  logic [7:0]       data_q,          data_d;
  logic             data_ready_q,    data_ready_d;
  logic             framing_error_q, framing_error_d;

  // Decides whether a correctly framed byte is forwarded downstream.
  logic             w_keep_byte;

`ifdef MIDI_RX_REALTIME_FILTER_EN
  // System Real-Time bytes occupy 8'hF8..8'hFF: top five bits all ones.
  assign w_keep_byte = (shift_q[7:3] != 5'b11111);
`else
  assign w_keep_byte = 1'b1;
`endif

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    data_d          = data_q;
    data_ready_d    = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A low level is enough: RECOVER guarantees the line was high first.
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid start bit means it was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;   // LSB arrives first
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (w_keep_byte) begin
              data_d       = shift_q;
              data_ready_d = 1'b1;
            end
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_RECOVER: begin
        // Hold off until the line returns high so a break reports one error.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign data          = data_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire
